// File: rtl/rv_wb_pkg.sv
// Shared writeback definitions: bus width, register-file geometry, entry width
// and a one-hot helper for building the pending-write mask.
package rv_wb_pkg;

  localparam int BUS_W      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // A writeback entry is packed as {rd, data}; rd occupies the top bits.
  localparam int WB_ENTRY_W = BUS_W + REG_ADDR_W;

  // One-hot register decode used by the pending-write mask.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] m;
    m     = '0;
    m[rd] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/rv_wb_fifo.sv
// Small per-source writeback FIFO. Entries are {rd, data}. Besides the usual
// push/pop/full/empty/count it exposes each slot's valid bit and rd field so
// the parent can build the pending-write mask without reaching into storage.
module rv_wb_fifo
  import rv_wb_pkg::*;
#(
  parameter int W     = WB_ENTRY_W,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [CW-1:0]              count,
  output logic [DEPTH-1:0]           entry_valid,
  output logic [DEPTH*REG_ADDR_W-1:0] entry_rd
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [DEPTH-1:0] vld;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign count       = cnt;
  assign entry_valid = vld;
  assign pop_data    = mem[rd_ptr];

  // Pointers wrap modulo DEPTH (power of two), count tracks occupancy, and
  // per-slot valid bits follow pushes and pops. A simultaneous push and pop
  // never hit the same slot: push needs a free slot, pop needs a filled one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      vld    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr      <= wr_ptr + AW'(1);
        vld[wr_ptr] <= 1'b1;
      end
      if (pop_ok) begin
        rd_ptr      <= rd_ptr + AW'(1);
        vld[rd_ptr] <= 1'b0;
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; contents of empty slots are don't-care, gated by vld.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_rd
    assign entry_rd[i*REG_ADDR_W +: REG_ADDR_W] = mem[i][W-1 -: REG_ADDR_W];
  end

endmodule

// File: rtl/rv_wb_arbiter.sv
// Writeback arbiter: ALU and LSU results are queued per source, the LSU queue
// has fixed priority, and one registered register-file write issues per cycle.
// pending_mask flags every register with a queued or currently driven write.
//
// Handshake: a source transfers on a rising edge where x_valid && x_ready.
// x_ready depends only on the registered FIFO count (never on the same-cycle
// dequeue) and is low while rst is high. Source data must stay stable until
// the transfer. A transfer with rd == 0 is accepted and dropped.
module rv_wb_arbiter
  import rv_wb_pkg::*;
#(
  parameter int DATA_W     = BUS_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0]     alu_data,
  output logic                  alu_ready,
  input  logic                  lsu_valid,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0]     lsu_data,
  output logic                  lsu_ready,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic [NUM_REGS-1:0]   pending_mask
);

  localparam int EW    = DATA_W + REG_ADDR_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                             alu_push, lsu_push;
  logic                             alu_pop, lsu_pop;
  logic [EW-1:0]                    alu_head, lsu_head, head;
  logic                             alu_full, lsu_full;
  logic                             alu_empty, lsu_empty;
  logic [CNT_W-1:0]                 alu_count, lsu_count;
  logic [FIFO_DEPTH-1:0]            alu_vld, lsu_vld;
  logic [FIFO_DEPTH*REG_ADDR_W-1:0] alu_rds, lsu_rds;
  logic                             issue;
  logic [NUM_REGS-1:0]              mask_c;

  assign alu_ready = !rst && (alu_count != CNT_W'(FIFO_DEPTH));
  assign lsu_ready = !rst && (lsu_count != CNT_W'(FIFO_DEPTH));

  // Writes to x0 are swallowed at the FIFO input.
  assign alu_push = alu_valid && !alu_full && (alu_rd != '0);
  assign lsu_push = lsu_valid && !lsu_full && (lsu_rd != '0);

  // Fixed priority: LSU first; the ALU only drains when the LSU queue is empty.
  assign lsu_pop = !lsu_empty;
  assign alu_pop = lsu_empty && !alu_empty;
  assign issue   = lsu_pop || alu_pop;
  assign head    = lsu_pop ? lsu_head : alu_head;

  rv_wb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (alu_push),
    .push_data   ({alu_rd, alu_data}),
    .pop         (alu_pop),
    .pop_data    (alu_head),
    .full        (alu_full),
    .empty       (alu_empty),
    .count       (alu_count),
    .entry_valid (alu_vld),
    .entry_rd    (alu_rds)
  );

  rv_wb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_lsu_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (lsu_push),
    .push_data   ({lsu_rd, lsu_data}),
    .pop         (lsu_pop),
    .pop_data    (lsu_head),
    .full        (lsu_full),
    .empty       (lsu_empty),
    .count       (lsu_count),
    .entry_valid (lsu_vld),
    .entry_rd    (lsu_rds)
  );

  // Register-file write port: pulse rf_we on a dequeue, hold address/data otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= issue;
      if (issue) begin
        rf_waddr <= head[EW-1 -: REG_ADDR_W];
        rf_wdata <= head[DATA_W-1:0];
      end
    end
  end

  // Pending mask: every queued rd in both FIFOs plus the write being driven.
  always_comb begin
    mask_c = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (alu_vld[i]) mask_c = mask_c | reg_onehot(alu_rds[i*REG_ADDR_W +: REG_ADDR_W]);
      if (lsu_vld[i]) mask_c = mask_c | reg_onehot(lsu_rds[i*REG_ADDR_W +: REG_ADDR_W]);
    end
    if (rf_we) mask_c = mask_c | reg_onehot(rf_waddr);
    mask_c[0] = 1'b0;
  end

  assign pending_mask = mask_c;

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// Bench for rv_wb_arbiter: directed scenarios plus randomized traffic,
// checked against a queue-level reference model and a write scoreboard.
module tb_rv_wb_arbiter;

  localparam int DW    = 32;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alu_valid = 1'b0;
  logic [4:0]    alu_rd = '0;
  logic [DW-1:0] alu_data = '0;
  logic          alu_ready;
  logic          lsu_valid = 1'b0;
  logic [4:0]    lsu_rd = '0;
  logic [DW-1:0] lsu_data = '0;
  logic          lsu_ready;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [31:0]   pending_mask;

  rv_wb_arbiter #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .lsu_valid    (lsu_valid),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .lsu_ready    (lsu_ready),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .pending_mask (pending_mask)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Two queues of accepted results; each edge the LSU queue drains first,
  // then the ALU queue, and the chosen entry becomes the driven write.
  ent_t          alu_q[$];
  ent_t          lsu_q[$];
  logic [DW+4:0] exp_q[$];
  logic          m_we    = 1'b0;
  logic [4:0]    m_waddr = '0;
  logic [DW-1:0] m_wdata = '0;
  bit            alu_xfer = 1'b0;
  bit            lsu_xfer = 1'b0;
  bit            a_rdy, l_rdy;
  ent_t          e_m;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_q.delete();
      lsu_q.delete();
      exp_q.delete();
      m_we     = 1'b0;
      m_waddr  = '0;
      m_wdata  = '0;
      alu_xfer = 1'b0;
      lsu_xfer = 1'b0;
    end else begin
      a_rdy = (alu_q.size() != DEPTH);
      l_rdy = (lsu_q.size() != DEPTH);
      m_we  = 1'b0;
      if (lsu_q.size() != 0) begin
        e_m = lsu_q.pop_front();
        m_we = 1'b1;
      end else if (alu_q.size() != 0) begin
        e_m = alu_q.pop_front();
        m_we = 1'b1;
      end
      if (m_we) begin
        m_waddr = e_m.rd;
        m_wdata = e_m.data;
        exp_q.push_back({e_m.rd, e_m.data});
      end
      alu_xfer = alu_valid && a_rdy;
      lsu_xfer = lsu_valid && l_rdy;
      if (alu_xfer && alu_rd != 0) alu_q.push_back('{rd: alu_rd, data: alu_data});
      if (lsu_xfer && lsu_rd != 0) lsu_q.push_back('{rd: lsu_rd, data: lsu_data});
    end
  end

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    foreach (alu_q[i]) m[alu_q[i].rd] = 1'b1;
    foreach (lsu_q[i]) m[lsu_q[i].rd] = 1'b1;
    if (m_we) m[m_waddr] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic [DW+4:0] sb_e;

  always @(negedge clk) begin
    check("alu_ready", alu_ready, !rst && (alu_q.size() != DEPTH));
    check("lsu_ready", lsu_ready, !rst && (lsu_q.size() != DEPTH));
    check("rf_we", rf_we, m_we);
    check("rf_waddr", rf_waddr, m_waddr);
    check("rf_wdata", rf_wdata, m_wdata);
    check("pending_mask", pending_mask, model_mask());
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_write", {rf_waddr, rf_wdata}, '0);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_write", {rf_waddr, rf_wdata}, sb_e);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic idle(input int n);
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  int ai, li;

  initial begin
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset_rf_we", rf_we, 1'b0);
    check("reset_mask", pending_mask, 32'h0);

    // Single ALU write.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    @(negedge clk);
    alu_valid = 1'b0;
    check("single_mask_queued", pending_mask, 32'h20);
    @(negedge clk);
    check("single_we", rf_we, 1'b1);
    check("single_addr_data", {rf_waddr, rf_wdata}, {5'd5, 32'h1234});
    @(negedge clk);
    check("single_mask_clear", pending_mask, 32'h0);
    check("single_we_low", rf_we, 1'b0);

    // Simultaneous sources: LSU wins.
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'hB;
    @(negedge clk);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    check("simul_mask0", pending_mask, 32'h18);
    @(negedge clk);
    check("simul_first", {rf_we, rf_waddr, rf_wdata}, {1'b1, 5'd4, 32'hB});
    check("simul_mask1", pending_mask, 32'h18);
    @(negedge clk);
    check("simul_second", {rf_we, rf_waddr, rf_wdata}, {1'b1, 5'd3, 32'hA});
    check("simul_mask2", pending_mask, 32'h08);
    @(negedge clk);
    check("simul_mask3", pending_mask, 32'h0);

    // x0 write is accepted and dropped.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    @(negedge clk);
    alu_valid = 1'b0;
    check("x0_mask", pending_mask, 32'h0);
    @(negedge clk);
    check("x0_no_write", rf_we, 1'b0);
    check("x0_mask_after", pending_mask, 32'h0);

    // Backpressure: LSU stream of 4 and ALU stream of 3 started together.
    ai = 0; li = 0;
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hA0;
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'hB0;
    for (int t = 0; t < 40 && (ai < 3 || li < 4); t++) begin
      @(negedge clk);
      if (alu_valid && alu_xfer) begin
        ai++;
        if (ai < 3) begin alu_rd = 5'(20 + ai); alu_data = 32'hA0 + ai; end
        else alu_valid = 1'b0;
      end
      if (lsu_valid && lsu_xfer) begin
        li++;
        if (li < 4) begin lsu_rd = 5'(10 + li); lsu_data = 32'hB0 + li; end
        else lsu_valid = 1'b0;
      end
    end
    check("bp_alu_sent", ai, 3);
    check("bp_lsu_sent", li, 4);
    idle(6);

    // Wrap-around: 8 back-to-back ALU results.
    for (int i = 1; i <= 8; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(i); alu_data = 32'h11 * i;
      @(negedge clk);
      check("wrap_accept", alu_xfer, 1'b1);
    end
    idle(4);

    // Reset mid-operation under heavy traffic.
    for (int c = 0; c < 6; c++) begin
      if (!alu_valid || alu_xfer) begin
        alu_valid = 1'b1; alu_rd = 5'($urandom_range(1, 31)); alu_data = $urandom;
      end
      if (!lsu_valid || lsu_xfer) begin
        lsu_valid = 1'b1; lsu_rd = 5'($urandom_range(1, 31)); lsu_data = $urandom;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async_we", rf_we, 1'b0);
    check("rst_async_mask", pending_mask, 32'h0);
    check("rst_async_ready", {alu_ready, lsu_ready}, 2'b00);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_no_write", rf_we, 1'b0);
    check("post_rst_ready", {alu_ready, lsu_ready}, 2'b11);

    // Randomized traffic respecting the handshake.
    for (int c = 0; c < 3000; c++) begin
      if (!alu_valid || alu_xfer) begin
        alu_valid = ($urandom_range(0, 99) < 60);
        alu_rd    = 5'($urandom_range(0, 31));
        alu_data  = $urandom;
      end
      if (!lsu_valid || lsu_xfer) begin
        lsu_valid = ($urandom_range(0, 99) < 35);
        lsu_rd    = 5'($urandom_range(0, 31));
        lsu_data  = $urandom;
      end
      @(negedge clk);
    end

    // Drain and confirm nothing is left outstanding.
    idle(10);
    check("drain_scoreboard_empty", exp_q.size(), 0);
    check("drain_mask", pending_mask, 32'h0);
    check("drain_we", rf_we, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
